// File: rtl/axi_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_write_arbiter_if
// Bundles the NB_SLAVE requesting AXI write ports (AW + W channels) and the
// single downstream master port that the arbiter drives.
//   s_aw_*  : per-port AW channel. Packed arrays are indexed by port.
//   s_w_*   : per-port W channel. Packed arrays are indexed by port.
//   m_aw_*  : merged AW channel. The port index is prepended to the ID.
//   m_w_*   : merged W channel.
// Modports:
//   slave  : the arbiter's view. It consumes requests and drives the master
//            channel.
//   master : the environment's view. It is made up of the requesters and the
//            downstream slave.
// ---------------------------------------------------------------------------
interface axi_write_arbiter_if #(
    parameter int NB_SLAVE       = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 10
);
    localparam int AXI_ID_OUT = AXI_ID_WIDTH + $clog2(NB_SLAVE);
    localparam int STRB_W     = AXI_DATA_WIDTH / 8;

    logic [NB_SLAVE-1:0]                     s_aw_valid_i;
    logic [NB_SLAVE-1:0]                     s_aw_ready_o;
    logic [NB_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] s_aw_addr_i;
    logic [NB_SLAVE-1:0][AXI_ID_WIDTH-1:0]   s_aw_id_i;
    logic [NB_SLAVE-1:0][7:0]                s_aw_len_i;

    logic [NB_SLAVE-1:0]                     s_w_valid_i;
    logic [NB_SLAVE-1:0]                     s_w_ready_o;
    logic [NB_SLAVE-1:0][AXI_DATA_WIDTH-1:0] s_w_data_i;
    logic [NB_SLAVE-1:0][STRB_W-1:0]         s_w_strb_i;
    logic [NB_SLAVE-1:0]                     s_w_last_i;

    logic                                    m_aw_valid_o;
    logic                                    m_aw_ready_i;
    logic [AXI_ADDR_WIDTH-1:0]               m_aw_addr_o;
    logic [AXI_ID_OUT-1:0]                   m_aw_id_o;
    logic [7:0]                              m_aw_len_o;

    logic                                    m_w_valid_o;
    logic                                    m_w_ready_i;
    logic [AXI_DATA_WIDTH-1:0]               m_w_data_o;
    logic [STRB_W-1:0]                       m_w_strb_o;
    logic                                    m_w_last_o;

    modport slave (
        input  s_aw_valid_i, s_aw_addr_i, s_aw_id_i, s_aw_len_i,
        output s_aw_ready_o,
        input  s_w_valid_i, s_w_data_i, s_w_strb_i, s_w_last_i,
        output s_w_ready_o,
        output m_aw_valid_o, m_aw_addr_o, m_aw_id_o, m_aw_len_o,
        input  m_aw_ready_i,
        output m_w_valid_o, m_w_data_o, m_w_strb_o, m_w_last_o,
        input  m_w_ready_i
    );

    modport master (
        output s_aw_valid_i, s_aw_addr_i, s_aw_id_i, s_aw_len_i,
        input  s_aw_ready_o,
        output s_w_valid_i, s_w_data_i, s_w_strb_i, s_w_last_i,
        input  s_w_ready_o,
        input  m_aw_valid_o, m_aw_addr_o, m_aw_id_o, m_aw_len_o,
        output m_aw_ready_i,
        input  m_w_valid_o, m_w_data_o, m_w_strb_o, m_w_last_o,
        output m_w_ready_i
    );
endinterface

// File: rtl/axi_write_arbiter.sv
// ---------------------------------------------------------------------------
// axi_write_arbiter
// Merges NB_SLAVE AXI write ports onto one master port. Only one burst is in
// flight at a time. A burst is one AW handshake followed by W beats up to and
// including WLAST. The winner is chosen by a round-robin pointer.
// Ports:
//   clk          : rising-edge clock.
//   rst_n        : asynchronous active-low reset.
//   bus          : axi_write_arbiter_if.slave. It carries the per-port
//                  AW and W channels and the merged master AW and W channels.
//   dbg_state_o  : current FSM state. 0 = IDLE, 1 = AW, 2 = W.
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. A valid, once raised, must hold its payload stable
// until the transfer completes; ready may be raised or dropped freely.
// ---------------------------------------------------------------------------
module axi_write_arbiter #(
    parameter int NB_SLAVE       = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    axi_write_arbiter_if.slave  bus,
    output logic [1:0]          dbg_state_o
);
    localparam int IDX_W      = $clog2(NB_SLAVE);
    localparam int AXI_ID_OUT = AXI_ID_WIDTH + IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic [IDX_W:0]   scan_sum;
    logic [IDX_W-1:0] scan_idx;

    // Round-robin search. Scan ports rr_q, rr_q+1, ... modulo NB_SLAVE and
    // take the first one that is requesting. The extra sum bit lets the wrap
    // work even when NB_SLAVE is not a power of two.
    always_comb begin
        winner   = '0;
        any_req  = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int i = 0; i < NB_SLAVE; i++) begin
            scan_sum = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (scan_sum >= (IDX_W+1)'(NB_SLAVE)) begin
                scan_sum = scan_sum - (IDX_W+1)'(NB_SLAVE);
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!any_req && bus.s_aw_valid_i[scan_idx]) begin
                any_req = 1'b1;
                winner  = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d   = winner;
                    rr_d    = (winner == IDX_W'(NB_SLAVE-1)) ? '0 : winner + 1'b1;
                    state_d = ST_AW;
                end
            end
            ST_AW: begin
                if (bus.m_aw_ready_i) begin
                    state_d = ST_W;
                end
            end
            ST_W: begin
                // WLAST alone closes the burst. AWLEN is not cross-checked.
                if (bus.s_w_valid_i[gnt_q] && bus.m_w_ready_i && bus.s_w_last_i[gnt_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Payloads always follow the granted port. Only the valid and ready
    // signals are gated by state, so requesters that are not granted cannot
    // disturb the master side.
    always_comb begin
        bus.m_aw_valid_o = 1'b0;
        bus.s_aw_ready_o = '0;
        bus.m_w_valid_o  = 1'b0;
        bus.s_w_ready_o  = '0;
        bus.m_aw_addr_o  = bus.s_aw_addr_i[gnt_q];
        bus.m_aw_id_o    = AXI_ID_OUT'({gnt_q, bus.s_aw_id_i[gnt_q]});
        bus.m_aw_len_o   = bus.s_aw_len_i[gnt_q];
        bus.m_w_data_o   = bus.s_w_data_i[gnt_q];
        bus.m_w_strb_o   = bus.s_w_strb_i[gnt_q];
        bus.m_w_last_o   = bus.s_w_last_i[gnt_q];
        case (state_q)
            ST_AW: begin
                bus.m_aw_valid_o        = 1'b1;
                bus.s_aw_ready_o[gnt_q] = bus.m_aw_ready_i;
            end
            ST_W: begin
                bus.m_w_valid_o        = bus.s_w_valid_i[gnt_q];
                bus.s_w_ready_o[gnt_q] = bus.m_w_ready_i;
            end
            default: ;
        endcase
    end

    assign dbg_state_o = state_q;

endmodule
